// File: rtl/exec_ctrl_pkg.sv
// Shared opcodes, ALU selects, FSM states and instruction field positions for exec_ctrl.
package exec_ctrl_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_LDI  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_BZ   = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_MOV  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   // ALU encoding is the opcode itself for the four ALU operations
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;

   localparam int IR_OPC_HI = 7;
   localparam int IR_OPC_LO = 5;
   localparam int IR_RD_HI  = 4;
   localparam int IR_RD_LO  = 3;
   localparam int IR_RS_HI  = 2;
   localparam int IR_RS_LO  = 1;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      IMM_FETCH,
      EXEC,
      HALT
   } state_t;

   function automatic logic is_alu_op(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   endfunction

endpackage

// File: rtl/exec_ctrl_regfile.sv
// 4x8 register file: two combinational read ports, one synchronous write port,
// synchronous active-low clear. EXEC_CTRL_DBG_PORT_EN adds a third read port.
module exec_regfile (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       we,
   input  logic [1:0] waddr,
   input  logic [7:0] wdata,
   input  logic [1:0] ra_addr,
   output logic [7:0] ra_data,
   input  logic [1:0] rb_addr,
   output logic [7:0] rb_data
`ifdef EXEC_CTRL_DBG_PORT_EN
   ,
   input  logic [1:0] dbg_addr,
   output logic [7:0] dbg_data
`endif
);

   logic [7:0] regs [4];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            regs[i] <= 8'h00;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign ra_data = regs[ra_addr];
   assign rb_data = regs[rb_addr];

`ifdef EXEC_CTRL_DBG_PORT_EN
   assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle fetch/decode/execute controller feeding a combinational ALU.
// Optional debug read port of the register file under EXEC_CTRL_DBG_PORT_EN.
//
// state     | meaning
// FETCH     | request opcode byte at pc, wait for imem_ack
// DECODE    | route to IMM_FETCH (LDI/BZ), HALT, or EXEC
// IMM_FETCH | request immediate byte at pc, wait for imem_ack
// EXEC      | write back / branch, pulse retire
// HALT      | idle until reset, no fetches
module exec_ctrl
   import exec_ctrl_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       imem_req,
   output logic [7:0] imem_addr,
   input  logic       imem_ack,
   input  logic [7:0] imem_rdata,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_ctrl,
   input  logic [7:0] alu_result,
   input  logic       alu_zero,
   output logic       z_flag,
   output logic       retire,
   output logic       halted
`ifdef EXEC_CTRL_DBG_PORT_EN
   ,
   input  logic [1:0] dbg_sel,
   output logic [7:0] dbg_data
`endif
);

   state_t     state;
   logic [7:0] pc;
   logic [7:0] imm;
   // bit 0 of the fetched byte carries no meaning, so only [7:1] is kept
   logic [IR_OPC_HI-IR_RS_LO:0] ir;

   logic [2:0] opcode;
   logic [1:0] rd;
   logic [1:0] rs;
   logic       rf_we;
   logic [7:0] rf_wdata;
   logic [7:0] rd_data;
   logic [7:0] rs_data;

   assign opcode = ir[IR_OPC_HI-IR_RS_LO:IR_OPC_LO-IR_RS_LO];
   assign rd     = ir[IR_RD_HI-IR_RS_LO:IR_RD_LO-IR_RS_LO];
   assign rs     = ir[IR_RS_HI-IR_RS_LO:IR_RS_LO-IR_RS_LO];

   assign imem_req  = rst_n && ((state == FETCH) || (state == IMM_FETCH));
   assign imem_addr = pc;
   assign alu_a     = rd_data;
   assign alu_b     = rs_data;

   always_comb begin
      alu_ctrl = ALU_ADD;
      if ((state == EXEC) && is_alu_op(opcode)) begin
         alu_ctrl = opcode;
      end
   end

   always_comb begin
      rf_we    = 1'b0;
      rf_wdata = alu_result;
      if (state == EXEC) begin
         if (is_alu_op(opcode)) begin
            rf_we    = 1'b1;
            rf_wdata = alu_result;
         end else if (opcode == OP_LDI) begin
            rf_we    = 1'b1;
            rf_wdata = imm;
         end else if (opcode == OP_MOV) begin
            rf_we    = 1'b1;
            rf_wdata = rs_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= FETCH;
         pc     <= RESET_PC;
         ir     <= '0;
         imm    <= 8'h00;
         z_flag <= 1'b0;
         retire <= 1'b0;
         halted <= 1'b0;
      end else begin
         retire <= 1'b0;
         case (state)
            FETCH: begin
               if (imem_ack) begin
                  ir    <= imem_rdata[IR_OPC_HI:IR_RS_LO];
                  pc    <= pc + 8'd1;
                  state <= DECODE;
               end
            end
            DECODE: begin
               case (opcode)
                  OP_LDI, OP_BZ: state <= IMM_FETCH;
                  OP_HALT: begin
                     state  <= HALT;
                     halted <= 1'b1;
                     retire <= 1'b1;
                  end
                  default: state <= EXEC;
               endcase
            end
            IMM_FETCH: begin
               if (imem_ack) begin
                  imm   <= imem_rdata;
                  pc    <= pc + 8'd1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               retire <= 1'b1;
               state  <= FETCH;
               if (is_alu_op(opcode)) begin
                  z_flag <= alu_zero;
               end
               if ((opcode == OP_BZ) && z_flag) begin
                  pc <= imm;
               end
            end
            HALT: begin
               halted <= 1'b1;
            end
            default: state <= FETCH;
         endcase
      end
   end

   exec_regfile u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (rf_we),
      .waddr    (rd),
      .wdata    (rf_wdata),
      .ra_addr  (rd),
      .ra_data  (rd_data),
      .rb_addr  (rs),
      .rb_data  (rs_data)
`ifdef EXEC_CTRL_DBG_PORT_EN
      ,
      .dbg_addr (dbg_sel),
      .dbg_data (dbg_data)
`endif
   );

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: behavioural ALU and byte memory around the DUT.
module tb_exec_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack;
   logic [7:0] imem_rdata;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] alu_ctrl;
   logic [7:0] alu_result;
   logic       alu_zero;
   logic       z_flag;
   logic       retire;
   logic       halted;
`ifdef EXEC_CTRL_DBG_PORT_EN
   logic [1:0] dbg_sel = 2'd2;
   logic [7:0] dbg_data;
`endif

   logic [7:0] mem [256];
   logic       ack_en = 1'b1;
   logic       ack_force = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign imem_ack   = ack_force | (ack_en & imem_req);
   assign imem_rdata = mem[imem_addr];

   always_comb begin
      case (alu_ctrl)
         3'b010:  alu_result = alu_a - alu_b;
         3'b100:  alu_result = alu_a & alu_b;
         3'b101:  alu_result = alu_a | alu_b;
         default: alu_result = alu_a + alu_b;
      endcase
   end
   assign alu_zero = (alu_result == 8'h00);

   exec_ctrl #(.RESET_PC(8'h00)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .z_flag     (z_flag),
      .retire     (retire),
      .halted     (halted)
`ifdef EXEC_CTRL_DBG_PORT_EN
      ,
      .dbg_sel    (dbg_sel),
      .dbg_data   (dbg_data)
`endif
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic run_instr(output int n);
      n = 0;
      do begin
         step(1);
         n++;
      end while (retire !== 1'b1 && n < 40);
   endtask

   task automatic load_program();
      for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
      mem[8'h00] = 8'h28; mem[8'h01] = 8'h05;   // LDI R1,05
      mem[8'h02] = 8'h30; mem[8'h03] = 8'h05;   // LDI R2,05
      mem[8'h04] = 8'h4C;                       // SUB R1,R2
      mem[8'h05] = 8'h60; mem[8'h06] = 8'h40;   // BZ 40
      mem[8'h40] = 8'h20; mem[8'h41] = 8'hF0;   // LDI R0,F0
      mem[8'h42] = 8'h28; mem[8'h43] = 8'h20;   // LDI R1,20
      mem[8'h44] = 8'h02;                       // ADD R0,R1
      mem[8'h45] = 8'hD8;                       // MOV R3,R0
      mem[8'h46] = 8'h60; mem[8'h47] = 8'h80;   // BZ 80 (not taken)
      mem[8'h48] = 8'h14;                       // ADD R2,R2
      mem[8'h49] = 8'h30; mem[8'h4A] = 8'hA5;   // LDI R2,A5
      mem[8'h4B] = 8'h5E;                       // SUB R3,R3
      mem[8'h4C] = 8'h60; mem[8'h4D] = 8'hFF;   // BZ FF
      mem[8'hFF] = 8'hC4;                       // MOV R0,R2
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(2);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b want=0", imem_req); end
      checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL rst_pc got=%h want=00", imem_addr); end
      checks++; if (retire !== 1'b0) begin failures++; $display("FAIL rst_retire got=%b want=0", retire); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b want=0", halted); end
      checks++; if (z_flag !== 1'b0) begin failures++; $display("FAIL rst_z got=%b want=0", z_flag); end
      checks++; if (alu_ctrl !== 3'b000) begin failures++; $display("FAIL rst_aluctrl got=%b want=000", alu_ctrl); end
      checks++; if (dut.u_rf.regs[1] !== 8'h00) begin failures++; $display("FAIL rst_r1 got=%h want=00", dut.u_rf.regs[1]); end
      rst_n = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL fetch_req got=%b want=1", imem_req); end
   endtask

   task automatic test_ldi();
      int n;
      run_instr(n);
      checks++; if (n != 4) begin failures++; $display("FAIL ldi_r1_cycles got=%0d want=4", n); end
      checks++; if (dut.u_rf.regs[1] !== 8'h05) begin failures++; $display("FAIL ldi_r1 got=%h want=05", dut.u_rf.regs[1]); end
      checks++; if (imem_addr !== 8'h02) begin failures++; $display("FAIL ldi_pc got=%h want=02", imem_addr); end
      checks++; if (z_flag !== 1'b0) begin failures++; $display("FAIL ldi_z got=%b want=0", z_flag); end
      run_instr(n);
      checks++; if (n != 4) begin failures++; $display("FAIL ldi_r2_cycles got=%0d want=4", n); end
      checks++; if (dut.u_rf.regs[2] !== 8'h05) begin failures++; $display("FAIL ldi_r2 got=%h want=05", dut.u_rf.regs[2]); end
   endtask

   task automatic test_sub_bz();
      int n;
      step(1);
      checks++; if (retire !== 1'b0) begin failures++; $display("FAIL retire_pulse got=%b want=0", retire); end
      checks++; if (alu_ctrl !== 3'b000) begin failures++; $display("FAIL decode_aluctrl got=%b want=000", alu_ctrl); end
      step(1);
      checks++; if (alu_ctrl !== 3'b010) begin failures++; $display("FAIL sub_aluctrl got=%b want=010", alu_ctrl); end
      checks++; if ({alu_a, alu_b} !== 16'h0505) begin failures++; $display("FAIL sub_operands got=%h want=0505", {alu_a, alu_b}); end
      step(1);
      checks++; if (retire !== 1'b1) begin failures++; $display("FAIL sub_retire got=%b want=1", retire); end
      checks++; if (dut.u_rf.regs[1] !== 8'h00) begin failures++; $display("FAIL sub_r1 got=%h want=00", dut.u_rf.regs[1]); end
      checks++; if (z_flag !== 1'b1) begin failures++; $display("FAIL sub_z got=%b want=1", z_flag); end
      checks++; if (imem_addr !== 8'h05) begin failures++; $display("FAIL sub_pc got=%h want=05", imem_addr); end
      run_instr(n);
      checks++; if (n != 4) begin failures++; $display("FAIL bz_cycles got=%0d want=4", n); end
      checks++; if (imem_addr !== 8'h40) begin failures++; $display("FAIL bz_taken_pc got=%h want=40", imem_addr); end
   endtask

   task automatic test_add_mov();
      int n;
      run_instr(n);
      checks++; if (dut.u_rf.regs[0] !== 8'hF0) begin failures++; $display("FAIL ldi_r0 got=%h want=f0", dut.u_rf.regs[0]); end
      checks++; if (z_flag !== 1'b1) begin failures++; $display("FAIL ldi_holds_z got=%b want=1", z_flag); end
      run_instr(n);
      checks++; if (dut.u_rf.regs[1] !== 8'h20) begin failures++; $display("FAIL ldi_r1b got=%h want=20", dut.u_rf.regs[1]); end
      run_instr(n);
      checks++; if (n != 3) begin failures++; $display("FAIL add_cycles got=%0d want=3", n); end
      checks++; if (dut.u_rf.regs[0] !== 8'h10) begin failures++; $display("FAIL add_r0 got=%h want=10", dut.u_rf.regs[0]); end
      checks++; if (z_flag !== 1'b0) begin failures++; $display("FAIL add_z got=%b want=0", z_flag); end
      run_instr(n);
      checks++; if (n != 3) begin failures++; $display("FAIL mov_cycles got=%0d want=3", n); end
      checks++; if (dut.u_rf.regs[3] !== 8'h10) begin failures++; $display("FAIL mov_r3 got=%h want=10", dut.u_rf.regs[3]); end
      checks++; if (z_flag !== 1'b0) begin failures++; $display("FAIL mov_z got=%b want=0", z_flag); end
      run_instr(n);
      checks++; if (imem_addr !== 8'h48) begin failures++; $display("FAIL bz_fall_pc got=%h want=48", imem_addr); end
   endtask

   task automatic test_wait_states();
      int n;
      ack_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         checks++;
         if ({imem_req, imem_addr, retire} !== {1'b1, 8'h48, 1'b0}) begin
            failures++;
            $display("FAIL wait_hold cyc=%0d got req=%b addr=%h retire=%b want req=1 addr=48 retire=0", i, imem_req, imem_addr, retire);
         end
      end
      ack_en = 1'b1;
      run_instr(n);
      checks++; if (n != 3) begin failures++; $display("FAIL wait_cycles got=%0d want=3", n); end
      checks++; if (dut.u_rf.regs[2] !== 8'h0A) begin failures++; $display("FAIL add_rd_eq_rs got=%h want=0a", dut.u_rf.regs[2]); end
      checks++; if (imem_addr !== 8'h49) begin failures++; $display("FAIL wait_pc got=%h want=49", imem_addr); end
      run_instr(n);
      checks++; if (dut.u_rf.regs[2] !== 8'hA5) begin failures++; $display("FAIL ldi_a5 got=%h want=a5", dut.u_rf.regs[2]); end
`ifdef EXEC_CTRL_DBG_PORT_EN
      checks++; if (dbg_data !== 8'hA5) begin failures++; $display("FAIL dbg_r2 got=%h want=a5", dbg_data); end
      dbg_sel = 2'd3;
      #1;
      checks++; if (dbg_data !== 8'h10) begin failures++; $display("FAIL dbg_r3 got=%h want=10", dbg_data); end
`endif
      run_instr(n);
      checks++; if (dut.u_rf.regs[3] !== 8'h00) begin failures++; $display("FAIL sub_self got=%h want=00", dut.u_rf.regs[3]); end
      checks++; if (z_flag !== 1'b1) begin failures++; $display("FAIL sub_self_z got=%b want=1", z_flag); end
      run_instr(n);
      checks++; if (imem_addr !== 8'hFF) begin failures++; $display("FAIL bz_ff_pc got=%h want=ff", imem_addr); end
   endtask

   task automatic test_wrap_reset();
      int n;
      run_instr(n);
      checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL pc_wrap got=%h want=00", imem_addr); end
      checks++; if (dut.u_rf.regs[0] !== 8'hA5) begin failures++; $display("FAIL mov_r0 got=%h want=a5", dut.u_rf.regs[0]); end
      checks++; if (z_flag !== 1'b1) begin failures++; $display("FAIL mov_holds_z got=%b want=1", z_flag); end
      step(2);
      ack_en = 1'b0;
      #1;
      checks++; if ({imem_req, imem_addr} !== {1'b1, 8'h01}) begin failures++; $display("FAIL imm_fetch got req=%b addr=%h want req=1 addr=01", imem_req, imem_addr); end
      rst_n = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_forces_req got=%b want=0", imem_req); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL midrst_pc got=%h want=00", imem_addr); end
      checks++; if ({z_flag, retire, halted} !== 3'b000) begin failures++; $display("FAIL midrst_flags got=%b want=000", {z_flag, retire, halted}); end
      checks++; if ({dut.u_rf.regs[0], dut.u_rf.regs[2]} !== 16'h0000) begin failures++; $display("FAIL midrst_regs got=%h want=0000", {dut.u_rf.regs[0], dut.u_rf.regs[2]}); end
   endtask

   task automatic test_halt();
      int n;
      mem[8'h00] = 8'hE0;
      ack_en = 1'b1;
      rst_n = 1'b1;
      run_instr(n);
      checks++; if (n != 2) begin failures++; $display("FAIL halt_cycles got=%0d want=2", n); end
      checks++; if ({halted, imem_req} !== 2'b10) begin failures++; $display("FAIL halt_entry got=%b want=10", {halted, imem_req}); end
      ack_force = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         checks++;
         if ({halted, retire, imem_req, imem_addr} !== {3'b100, 8'h01}) begin
            failures++;
            $display("FAIL halt_hold cyc=%0d got halted=%b retire=%b req=%b addr=%h want 1 0 0 01", i, halted, retire, imem_req, imem_addr);
         end
      end
      ack_force = 1'b0;
   endtask

   initial begin
      load_program();
      @(negedge clk);
      test_reset();
      test_ldi();
      test_sub_bz();
      test_add_mov();
      test_wait_states();
      test_wrap_reset();
      test_halt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
- Multi-cycle fetch/decode/execute controller for the 8-bit processor. It sits directly upstream of the combinational ALU and consumes the ALU's result.
- Fetches instruction bytes over a req/ack memory handshake and holds a 4x8 register file.
- Drives the ALU operands and function select, then writes the ALU result and zero flag back.
- Handles immediate loads, moves, a branch-on-zero and halt.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request; high in FETCH/IMM_FETCH, forced 0 while rst_n=0.
- imem_addr  out  8  fetch address, equals pc.
- imem_ack  in  1  memory has valid imem_rdata this cycle.
- imem_rdata  in  8  fetched byte.
- alu_a  out  8  ALU src1 = R[rd].
- alu_b  out  8  ALU src2 = R[rs].
- alu_ctrl  out  3  ALU function select.
- alu_result  in  8  ALU result, combinational, same cycle.
- alu_zero  in  1  ALU zero output.
- z_flag  out  1  registered zero flag.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  high while in HALT.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: pc=RESET_PC, R0..R3=0, ir=0, imm=0, z_flag=0, retire=0, halted=0, state=FETCH. Reset mid-operation abandons any pending fetch.
- Instruction byte ir is decoded as:
  - opcode = ir[7:5]
  - rd = ir[4:3]
  - rs = ir[2:1]
  - ir[0] is ignored.
- Opcodes:
  - 000 ADD, 010 SUB, 100 AND, 101 OR: R[rd] <= alu_result; z_flag <= alu_zero.
  - 001 LDI: two-byte instruction; R[rd] <= imm.
  - 011 BZ: two-byte instruction; if z_flag=1 then pc <= imm, else fall through.
  - 110 MOV: R[rd] <= R[rs].
  - 111 HALT.
- alu_ctrl = opcode for ADD/SUB/AND/OR in EXEC, else 3'b000. alu_a and alu_b always reflect R[rd] and R[rs] of the current ir.
- States:
  - FETCH: imem_req=1, imem_addr=pc. Stay until imem_ack. On ack: ir <= imem_rdata, pc <= pc+1, go to DECODE.
  - DECODE: LDI/BZ -> IMM_FETCH; HALT -> HALT; otherwise -> EXEC.
  - IMM_FETCH: imem_req=1, imem_addr=pc. On ack: imm <= imem_rdata, pc <= pc+1, go to EXEC.
  - EXEC: perform the op, pulse retire=1, go to FETCH.
  - HALT: halted=1, imem_req=0. Stays here until reset; retire pulses once on entry.
- Latency with zero-wait memory (ack in the same cycle as req):
  - ALU op and MOV: 3 cycles (FETCH, DECODE, EXEC).
  - LDI and BZ: 4 cycles.
  - Each wait cycle before imem_ack adds one cycle.
- Arithmetic and width rules:
  - pc increments modulo 256; 8'hFF+1 wraps to 8'h00.
  - ALU results are 8-bit; carry is discarded, as the ALU provides no carry.
  - z_flag changes only on ADD/SUB/AND/OR. It holds across LDI, MOV and BZ.
- Boundary conditions:
  - rd==rs is legal; the ALU reads the old value and writes back at the EXEC edge.
  - imem_ack while imem_req=0 is ignored.
  - imem_rdata is sampled only on the ack cycle.

Optional Feature:
- Macro EXEC_CTRL_DBG_PORT_EN.
- Defined: adds ports dbg_sel (in, 2) and dbg_data (out, 8). dbg_data = R[dbg_sel], combinational read with no side effect on execution.
- Undefined: these ports do not exist and the register file has only its internal read ports.

Decomposition:
- Shared package:
  - opcode constants OP_ADD=3'b000, OP_LDI=3'b001, OP_SUB=3'b010, OP_BZ=3'b011, OP_AND=3'b100, OP_OR=3'b101, OP_MOV=3'b110, OP_HALT=3'b111
  - ALU select constants matching the ALU encoding
  - state enum {FETCH, DECODE, IMM_FETCH, EXEC, HALT}
  - field-slice constants for opcode/rd/rs.
- One sub-module, exec_regfile: 4x8 registers, two combinational read ports, one synchronous write port, synchronous active-low clear. When EXEC_CTRL_DBG_PORT_EN is defined it has a third read port for the debug output.

Test Plan:
- Reset then LDI R1,8'h05 (bytes 8'h28, 8'h05) with zero-wait ack -> after 4 cycles R1=8'h05, pc=8'h02, retire pulses once, z_flag=0.
- With R1=8'h05 and R2=8'h05, SUB R1,R2 (8'h4C) -> alu_ctrl=3'b010 in EXEC, R1=8'h00, z_flag=1. A following BZ 8'h40 loads pc=8'h40; the same BZ with z_flag=0 gives pc=old pc+2.
- ADD R0,R1 with R0=8'hF0 and R1=8'h20 -> R0=8'h10 (carry dropped), z_flag=0. A following MOV R3,R0 (8'hD8) -> R3=8'h10 and z_flag unchanged.
- Hold imem_ack low for 5 cycles during FETCH -> imem_req and imem_addr held stable, no state change; on ack, ir is captured and pc advances by exactly 1.
- pc=8'hFF fetching a one-byte op -> pc wraps to 8'h00. Then HALT (8'hE0) -> halted=1, imem_req=0 thereafter. Reset asserted mid-IMM_FETCH -> all outputs return to reset values on the next edge.
- With EXEC_CTRL_DBG_PORT_EN defined, after loading R2=8'hA5 -> dbg_sel=2 gives dbg_data=8'hA5 and execution is unaffected.
